fft_band_receiver: RTL

- Avalon-ST sink that consumes the FFT core's source stream: 512-point complex frames delimited by sop/eop.
- Computes per-bin magnitude |re|+|im| and sums consecutive bins into spectral bands for the visualiser.
- Publishes a complete band vector with a one-cycle done pulse per good frame. Malformed frames are flagged and discarded.
- Sits between the FFT core source port and the display/LED drivers.

---
 rtl/fft_pkg.sv | 9 +
 rtl/cplx_mag_abs.sv | 13 +
 rtl/fft_band_receiver.sv | 116 +++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT source-beat layout, default frame length and receiver state encoding.
package fft_pkg;
    localparam int REAL_MSB      = 41;
    localparam int REAL_LSB      = 26;
    localparam int IMAG_MSB      = 25;
    localparam int IMAG_LSB      = 10;
    localparam int DEF_FRAME_LEN = 512;
    typedef enum logic [1:0] {S_IDLE, S_RECV, S_DRAIN} rx_state_e;
endpackage

// File: rtl/cplx_mag_abs.sv
// cplx_mag_abs: |re|+|im| of a signed complex sample, exact over the full input range.
module cplx_mag_abs (
    input  logic signed [15:0] re_i,
    input  logic signed [15:0] im_i,
    output logic        [16:0] mag_o
);
    logic [16:0] re_x, im_x;
    always_comb begin
        re_x  = {re_i[15], re_i};
        im_x  = {im_i[15], im_i};
        mag_o = (re_i[15] ? -re_x : re_x) + (im_i[15] ? -im_x : im_x);
    end
endmodule

// File: rtl/fft_band_receiver.sv
// fft_band_receiver: Avalon-ST sink for FFT frames; sums |re|+|im| of the
// lower-half bins into bands and publishes them once per well-formed frame.
module fft_band_receiver
    import fft_pkg::*;
#(
    parameter int FRAME_LEN     = DEF_FRAME_LEN,
    parameter int NUM_BANDS     = 16,
    parameter int BINS_PER_BAND = 16,
    parameter int OUT_SHIFT     = 5
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic                       i_sop,
    input  logic                       i_eop,
    input  logic [41:0]                i_data,
    output logic [NUM_BANDS-1:0][15:0] o_bands,
    output logic                       o_frame_done,
    output logic                       o_frame_err
);
    localparam int CW = $clog2(FRAME_LEN);
    localparam int SW = $clog2(BINS_PER_BAND);
    localparam int BW = $clog2(NUM_BANDS);
    localparam int AW = 21;

    rx_state_e                  state_q;
    logic [CW-1:0]              count_q;
    logic                       drain_q;
    logic                       s1_valid_q;
    logic [16:0]                s1_mag_q;
    logic [BW-1:0]              s1_band_q;
    logic [AW-1:0]              acc_q [NUM_BANDS];
    logic [NUM_BANDS-1:0][15:0] bands_q;
    logic                       done_q, err_q;
    logic                       accept, last_bin, lo_half, unused_ok;
    logic [16:0]                mag;

    cplx_mag_abs u_mag (
        .re_i (i_data[REAL_MSB:REAL_LSB]),
        .im_i (i_data[IMAG_MSB:IMAG_LSB]),
        .mag_o(mag)
    );

    assign o_ready      = state_q != S_DRAIN;
    assign accept       = i_valid && o_ready;
    assign last_bin     = count_q == CW'(FRAME_LEN - 1);
    assign lo_half      = (count_q >> (SW + BW)) == '0;
    assign unused_ok    = ^i_data[IMAG_LSB-1:0];
    assign o_bands      = bands_q;
    assign o_frame_done = done_q;
    assign o_frame_err  = err_q;

    // Stage 1 keeps the band index of the bin; s1_valid_q is cleared for mirror bins.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            drain_q    <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_mag_q   <= '0;
            s1_band_q  <= '0;
            bands_q    <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            for (int k = 0; k < NUM_BANDS; k++) acc_q[k] <= '0;
        end else begin
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_mag_q   <= mag;
            if (s1_valid_q) acc_q[s1_band_q] <= acc_q[s1_band_q] + AW'(s1_mag_q);
            case (state_q)
                S_IDLE: if (accept && i_sop) begin
                    s1_valid_q <= 1'b1;
                    s1_band_q  <= '0;
                    count_q    <= CW'(1);
                    state_q    <= S_RECV;
                end
                S_RECV: if (accept) begin
                    if (i_sop) begin
                        // Restart overrides stage 1, so no bin of the dropped frame lands after the clear.
                        err_q      <= 1'b1;
                        s1_valid_q <= 1'b1;
                        s1_band_q  <= '0;
                        count_q    <= CW'(1);
                        for (int k = 0; k < NUM_BANDS; k++) acc_q[k] <= '0;
                    end else if (i_eop ^ last_bin) begin
                        err_q   <= 1'b1;
                        count_q <= '0;
                        state_q <= S_IDLE;
                        for (int k = 0; k < NUM_BANDS; k++) acc_q[k] <= '0;
                    end else begin
                        s1_valid_q <= lo_half;
                        s1_band_q  <= count_q[SW +: BW];
                        count_q    <= count_q + CW'(1);
                        if (i_eop) state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    drain_q <= !drain_q;
                    if (drain_q) begin
                        done_q  <= 1'b1;
                        count_q <= '0;
                        state_q <= S_IDLE;
                        for (int k = 0; k < NUM_BANDS; k++) begin
                            bands_q[k] <= 16'(acc_q[k] >> OUT_SHIFT);
                            acc_q[k]   <= '0;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule
